fetch_unit: RTL

- Instruction fetch stage: owns the PC, issues word reads to instruction memory and buffers the returned words in a small in-order prefetch FIFO.
- Presents {instruction, PC} to the decode stage, where the main control decoder consumes opcode[6:0], over a valid/ready handshake.
- Accepts redirects (taken branch / jal) from execute, flushes buffered and in-flight fetches, and restarts at the new PC.

---
 rtl/fetch_unit_pkg.sv | 43 ++++
 rtl/fetch_unit_fifo.sv | 56 +++++
 rtl/fetch_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: instruction format classes, the
// predecode helper and the prefetch FIFO entry layout.
// Optional macro FETCH_PREDECODE_EN adds a format field to each entry.
package fetch_unit_pkg;

  localparam int INST_BYTES = 4;
  localparam int FETCH_PC_W = 32;

  typedef enum logic [2:0] {
    r_format = 3'd0,
    i_format = 3'd1,
    s_format = 3'd2,
    b_format = 3'd3,
    u_format = 3'd4,
    j_format = 3'd5,
    x_format = 3'd7
  } instr_format;

  // Classify a 32-bit instruction from opcode bits [6:2].
  function automatic instr_format decode32_format(input logic [4:0] op);
    instr_format fmt;
    fmt = x_format;
    case (op)
      5'b01100, 5'b01110:                                     fmt = r_format;
      5'b00000, 5'b00100, 5'b00110, 5'b11001, 5'b11100, 5'b00011: fmt = i_format;
      5'b01000:                                               fmt = s_format;
      5'b11000:                                               fmt = b_format;
      5'b01101, 5'b00101:                                     fmt = u_format;
      5'b11011:                                               fmt = j_format;
      default:                                                fmt = x_format;
    endcase
    return fmt;
  endfunction

  typedef struct packed {
    logic [31:0]           inst;
    logic [FETCH_PC_W-1:0] pc;
`ifdef FETCH_PREDECODE_EN
    instr_format           fmt;
`endif
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: synchronous in-order prefetch buffer of DEPTH entries
// (DEPTH a power of two). Head is read combinationally from storage.
// A flush empties the buffer; a push in the flush cycle is discarded.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == PW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Read/write pointers; flush returns both to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)          wr_ptr <= wr_ptr + PW'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Entry storage; cleared on reset so the head reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues word reads to instruction memory,
// buffers returned words in fetch_fifo and hands {inst, pc} to decode.
// Optional macro FETCH_PREDECODE_EN adds the inst_fmt output.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// A source holds valid and its payload stable until the transfer, except
// that a redirect withdraws the pending fetch request. Ready may depend
// on valid; valid never depends on ready.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [PC_W-1:0] inst_pc,
`ifdef FETCH_PREDECODE_EN
  output instr_format     inst_fmt,
`endif
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int UW = CW + 1;

  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] rsp_pc;
  logic [PC_W-1:0] redirect_base;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_next;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   fifo_count;
  logic [UW-1:0]   used;
  logic            accept;
  logic            keep;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // Credits count both buffered words and requests still in flight, so
  // every kept response is guaranteed a FIFO slot.
  assign redirect_base    = redirect_pc & ~PC_W'(3);
  assign used             = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req_valid   = rst_n && !redirect_valid && (used < UW'(DEPTH));
  assign imem_addr        = fetch_pc;
  assign accept           = imem_req_valid && imem_req_ready;
  assign keep             = imem_rsp_valid && (drop == '0);
  assign push             = keep && !redirect_valid;
  assign pop              = inst_valid && inst_ready;
  assign outstanding_next = outstanding + CW'(accept) - CW'(imem_rsp_valid);

  assign inst_valid = !fifo_empty;
  assign inst       = head.inst;
  assign inst_pc    = PC_W'(head.pc);
`ifdef FETCH_PREDECODE_EN
  assign inst_fmt   = head.fmt;
`endif

  // Build the FIFO entry for the response arriving this cycle.
  always_comb begin
    push_entry      = '0;
    push_entry.inst = imem_rdata;
    push_entry.pc   = FETCH_PC_W'(rsp_pc);
`ifdef FETCH_PREDECODE_EN
    push_entry.fmt  = decode32_format(imem_rdata[6:2]);
`endif
  end

  // Request PC and response PC; a redirect restarts both at the target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_base;
      rsp_pc   <= redirect_base;
    end else begin
      if (accept) fetch_pc <= fetch_pc + PC_W'(INST_BYTES);
      if (keep)   rsp_pc   <= rsp_pc + PC_W'(INST_BYTES);
    end
  end

  // In-flight count and the number of stale responses still to discard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_valid)                      drop <= outstanding_next;
      else if (imem_rsp_valid && drop != '0)   drop <= drop - CW'(1);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (head)
  );

  // The credit limit means a kept response never meets a full buffer.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));

endmodule
